tft_src_sched: RTL and testbench

Pixel-source scheduler between the two camera frame-buffer read FIFOs and the TFT timing controller. Driven by the controller's `data_req`, `pix_x` and `vsync`, it decides per pixel which camera FIFO to pop and returns registered RGB565 data to the controller's `data_in`. It also supports full-screen, side-by-side split and test-pattern modes, switches mode only on frame boundaries, issues per-camera frame-start pulses to the DDR read side, and counts FIFO underflows.

---
 rtl/tft_sched_pkg.sv | 39 +++
 rtl/tft_colorbar_gen.sv | 58 +++++
 rtl/tft_src_sched.sv | 187 ++++++++++++++++++
 tb/tb_tft_src_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_sched_pkg.sv
// Shared definitions for the TFT pixel-source scheduler.
// Contents: display mode encodings, the eight colour-bar RGB565 constants
// and a lookup function mapping a bar index to its colour.
package tft_sched_pkg;

  typedef enum logic [1:0] {
    MODE_CAM0  = 2'd0,
    MODE_CAM1  = 2'd1,
    MODE_SPLIT = 2'd2,
    MODE_BARS  = 2'd3
  } mode_e;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  // Bar index 0..7 from the left edge of the screen to its RGB565 colour.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      3'd7:    col = COL_BLACK;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/tft_colorbar_gen.sv
// Colour-bar pattern generator.
// Counts pixel requests along a line and reports the colour of the bar that
// the current request falls in. Both counters return to zero whenever the
// request line is low, so every line restarts at the white bar.
// Ports:
//   clk_i       pixel clock
//   rst_i       synchronous active-high reset
//   data_req_i  pixel request from the timing controller
//   color_o     RGB565 colour for the request in the current cycle
module tft_colorbar_gen
  import tft_sched_pkg::*;
#(
  parameter int H_PIXEL = 800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic [15:0] color_o
);

  localparam int BAR_W = H_PIXEL / 8;
  localparam logic [15:0] WIDTH_LAST = 16'(BAR_W - 1);

  logic [2:0]  bar_q;
  logic [2:0]  bar_d;
  logic [15:0] width_q;
  logic [15:0] width_d;

  // Next-state for the bar/width counters: advance per request, clear when idle.
  always_comb begin
    bar_d   = bar_q;
    width_d = width_q;
    if (!data_req_i) begin
      bar_d   = 3'd0;
      width_d = 16'd0;
    end else if (width_q == WIDTH_LAST) begin
      bar_d   = bar_q + 3'd1;
      width_d = 16'd0;
    end else begin
      bar_d   = bar_q;
      width_d = width_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bar_q   <= 3'd0;
      width_q <= 16'd0;
    end else begin
      bar_q   <= bar_d;
      width_q <= width_d;
    end
  end

  assign color_o = bar_color(bar_q);

endmodule

// File: rtl/tft_src_sched.sv
// Pixel-source scheduler between two camera read FIFOs and the TFT timing
// controller. Decides per requested pixel which show-ahead FIFO to pop and
// returns the registered RGB565 pixel one cycle later.
// Ports:
//   clk_in, sys_rst               pixel clock, synchronous active-high reset
//   cfg_mode                      requested mode, adopted on vsync rising edge
//   data_req, pix_x, vsync        timing controller request / x / field sync
//   camN_rd_data, camN_empty      show-ahead FIFO head and empty flag
//   camN_rd_en                    combinational FIFO pop
//   camN_frame_start              one-cycle frame reload pulse
//   pix_data                      registered pixel for the previous request
//   mode_active                   mode in effect for the current frame
//   ufl_cnt0, ufl_cnt1            underflow counts of the previous frame
module tft_src_sched
  import tft_sched_pkg::*;
#(
  parameter int          H_PIXEL   = 800,
  parameter int          H_SPLIT   = 400,
  parameter logic [15:0] UFL_COLOR = 16'hF800
) (
  input  logic        clk_in,
  input  logic        sys_rst,
  input  logic [1:0]  cfg_mode,
  input  logic        data_req,
  input  logic [10:0] pix_x,
  input  logic        vsync,
  input  logic [15:0] cam0_rd_data,
  input  logic [15:0] cam1_rd_data,
  input  logic        cam0_empty,
  input  logic        cam1_empty,
  output logic        cam0_rd_en,
  output logic        cam1_rd_en,
  output logic        cam0_frame_start,
  output logic        cam1_frame_start,
  output logic [15:0] pix_data,
  output logic [1:0]  mode_active,
  output logic [15:0] ufl_cnt0,
  output logic [15:0] ufl_cnt1
);

  localparam logic [10:0] SPLIT_X = 11'(H_SPLIT);

  logic        vsync_q;
  logic        armed_q;
  mode_e       mode_q;
  logic        fs0_q, fs0_d;
  logic        fs1_q, fs1_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic [15:0] ufl0_q, ufl1_q;

  logic        vs_rise;
  logic        armed_now;
  mode_e       mode_now;
  logic        req_ok;
  logic        sel0, sel1;
  logic        ufl0, ufl1;
  logic [15:0] bar_col;

  tft_colorbar_gen #(
    .H_PIXEL (H_PIXEL)
  ) u_bars (
    .clk_i      (clk_in),
    .rst_i      (sys_rst),
    .data_req_i (data_req),
    .color_o    (bar_col)
  );

  // A frame edge takes effect in its own cycle: a request coincident with the
  // edge already sees the new mode and the armed state.
  assign vs_rise   = vsync & ~vsync_q;
  assign armed_now = armed_q | vs_rise;
  assign mode_now  = vs_rise ? mode_e'(cfg_mode) : mode_q;
  assign req_ok    = ~sys_rst & armed_now & data_req;

  // Source selection for the current request.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    case (mode_now)
      MODE_CAM0:  sel0 = 1'b1;
      MODE_CAM1:  sel1 = 1'b1;
      MODE_SPLIT: begin
        if (pix_x < SPLIT_X) sel0 = 1'b1;
        else                 sel1 = 1'b1;
      end
      MODE_BARS: begin
        sel0 = 1'b0;
        sel1 = 1'b0;
      end
      default: begin
        sel0 = 1'b0;
        sel1 = 1'b0;
      end
    endcase
  end

  assign cam0_rd_en = req_ok & sel0 & ~cam0_empty;
  assign cam1_rd_en = req_ok & sel1 & ~cam1_empty;
  assign ufl0       = req_ok & sel0 & cam0_empty;
  assign ufl1       = req_ok & sel1 & cam1_empty;

  // Pixel to present next cycle; FIFO head is valid in the pop cycle.
  always_comb begin
    pix_d = 16'h0000;
    if (!req_ok) begin
      pix_d = 16'h0000;
    end else if (mode_now == MODE_BARS) begin
      pix_d = bar_col;
    end else if (sel0) begin
      pix_d = cam0_empty ? UFL_COLOR : cam0_rd_data;
    end else if (sel1) begin
      pix_d = cam1_empty ? UFL_COLOR : cam1_rd_data;
    end else begin
      pix_d = 16'h0000;
    end
  end

  // Underflow counters: restart at the frame edge, otherwise saturating count.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (vs_rise) begin
      cnt0_d = ufl0 ? 16'd1 : 16'd0;
      cnt1_d = ufl1 ? 16'd1 : 16'd0;
    end else begin
      if (ufl0 && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
      else                              cnt0_d = cnt0_q;
      if (ufl1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
      else                              cnt1_d = cnt1_q;
    end
  end

  // Frame-start pulses only for cameras the incoming mode actually reads.
  always_comb begin
    fs0_d = 1'b0;
    fs1_d = 1'b0;
    if (vs_rise) begin
      fs0_d = (mode_e'(cfg_mode) == MODE_CAM0) || (mode_e'(cfg_mode) == MODE_SPLIT);
      fs1_d = (mode_e'(cfg_mode) == MODE_CAM1) || (mode_e'(cfg_mode) == MODE_SPLIT);
    end else begin
      fs0_d = 1'b0;
      fs1_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
      mode_q  <= MODE_CAM0;
      fs0_q   <= 1'b0;
      fs1_q   <= 1'b0;
      pix_q   <= 16'h0000;
      cnt0_q  <= 16'd0;
      cnt1_q  <= 16'd0;
      ufl0_q  <= 16'd0;
      ufl1_q  <= 16'd0;
    end else begin
      vsync_q <= vsync;
      armed_q <= armed_now;
      mode_q  <= mode_now;
      fs0_q   <= fs0_d;
      fs1_q   <= fs1_d;
      pix_q   <= pix_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      if (vs_rise) begin
        ufl0_q <= cnt0_q;
        ufl1_q <= cnt1_q;
      end else begin
        ufl0_q <= ufl0_q;
        ufl1_q <= ufl1_q;
      end
    end
  end

  assign cam0_frame_start = fs0_q;
  assign cam1_frame_start = fs1_q;
  assign pix_data         = pix_q;
  assign mode_active      = mode_q;
  assign ufl_cnt0         = ufl0_q;
  assign ufl_cnt1         = ufl1_q;

endmodule

// File: tb/tb_tft_src_sched.sv
// Self-checking bench for tft_src_sched: scoreboard of expected pixels,
// one task per scenario.
`timescale 1ns/1ps
module tb_tft_src_sched;

  logic        clk_in = 1'b0;
  logic        sys_rst;
  logic [1:0]  cfg_mode;
  logic        data_req;
  logic [10:0] pix_x;
  logic        vsync;
  logic [15:0] cam0_rd_data, cam1_rd_data;
  logic        cam0_empty, cam1_empty;
  logic        cam0_rd_en, cam1_rd_en;
  logic        cam0_frame_start, cam1_frame_start;
  logic [15:0] pix_data;
  logic [1:0]  mode_active;
  logic [15:0] ufl_cnt0, ufl_cnt1;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_pix;
  logic [15:0] bar_tab [0:7];

  always #5 clk_in = ~clk_in;

  tft_src_sched dut (
    .clk_in(clk_in), .sys_rst(sys_rst), .cfg_mode(cfg_mode), .data_req(data_req),
    .pix_x(pix_x), .vsync(vsync), .cam0_rd_data(cam0_rd_data), .cam1_rd_data(cam1_rd_data),
    .cam0_empty(cam0_empty), .cam1_empty(cam1_empty), .cam0_rd_en(cam0_rd_en),
    .cam1_rd_en(cam1_rd_en), .cam0_frame_start(cam0_frame_start),
    .cam1_frame_start(cam1_frame_start), .pix_data(pix_data), .mode_active(mode_active),
    .ufl_cnt0(ufl_cnt0), .ufl_cnt1(ufl_cnt1)
  );

  task automatic idle(input int n);
    data_req = 1'b0;
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic vsync_edge();
    data_req = 1'b0;
    vsync = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic vsync_end();
    repeat (3) begin @(posedge clk_in); #1; end
    vsync = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    cam0_empty = 1'b0; cam1_empty = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    n_chk++;
    if (pix_data !== 16'h0 || mode_active !== 2'd0 || ufl_cnt0 !== 16'h0 || ufl_cnt1 !== 16'h0 ||
        cam0_frame_start !== 1'b0 || cam1_frame_start !== 1'b0)
      $display("FAIL reset_state got pix=%h mode=%0d u0=%h u1=%h fs=%b%b exp all 0",
               pix_data, mode_active, ufl_cnt0, ufl_cnt1, cam0_frame_start, cam1_frame_start);
    else n_pass++;
    sys_rst = 1'b0;
    // Not yet armed: requests must not pop and must return 0.
    for (int x = 0; x < 5; x++) begin
      data_req = 1'b1; pix_x = 11'(x); cam0_rd_data = 16'h1234;
      @(negedge clk_in);
      n_chk++;
      if (cam0_rd_en !== 1'b0 || cam1_rd_en !== 1'b0)
        $display("FAIL unarmed_pop x=%0d got rd=%b%b exp 00", x, cam0_rd_en, cam1_rd_en);
      else n_pass++;
      exp_q.push_back(16'h0000);
      @(posedge clk_in); #1;
      exp_pix = exp_q.pop_front();
      n_chk++;
      if (pix_data !== exp_pix) $display("FAIL unarmed_pix x=%0d got %h exp %h", x, pix_data, exp_pix);
      else n_pass++;
    end
    idle(3);
  endtask

  task automatic test_mode0();
    logic [15:0] ramp;
    int pops0, pops1;
    ramp = 16'h0000;
    cfg_mode = 2'd0;
    vsync_edge();
    n_chk++;
    if (mode_active !== 2'd0 || cam0_frame_start !== 1'b1 || cam1_frame_start !== 1'b0)
      $display("FAIL m0_edge got mode=%0d fs=%b%b exp 0 10", mode_active, cam0_frame_start, cam1_frame_start);
    else n_pass++;
    vsync_end(); idle(4);
    for (int line = 0; line < 2; line++) begin
      pops0 = 0; pops1 = 0;
      for (int x = 0; x < 800; x++) begin
        data_req = 1'b1; pix_x = 11'(x); cam0_rd_data = ramp; cam0_empty = 1'b0;
        @(negedge clk_in);
        pops0 = pops0 + int'(cam0_rd_en); pops1 = pops1 + int'(cam1_rd_en);
        exp_q.push_back(ramp); ramp = ramp + 16'd1;
        @(posedge clk_in); #1;
        exp_pix = exp_q.pop_front();
        n_chk++;
        if (pix_data !== exp_pix) $display("FAIL m0_pix x=%0d got %h exp %h", x, pix_data, exp_pix);
        else n_pass++;
      end
      data_req = 1'b0;
      n_chk++;
      if (pops0 != 800 || pops1 != 0) $display("FAIL m0_pops got %0d/%0d exp 800/0", pops0, pops1);
      else n_pass++;
      @(posedge clk_in); #1;
      n_chk++;
      if (pix_data !== 16'h0) $display("FAIL idle_pix got %h exp 0000", pix_data);
      else n_pass++;
      idle(5);
    end
  endtask

  task automatic test_split();
    int pops0, pops1;
    cfg_mode = 2'd2;
    vsync_edge();
    n_chk++;
    if (mode_active !== 2'd2 || cam0_frame_start !== 1'b1 || cam1_frame_start !== 1'b1)
      $display("FAIL split_edge got mode=%0d fs=%b%b exp 2 11", mode_active, cam0_frame_start, cam1_frame_start);
    else n_pass++;
    vsync_end(); idle(4);
    pops0 = 0; pops1 = 0;
    cam0_rd_data = 16'h1111; cam1_rd_data = 16'h2222;
    cam0_empty = 1'b0; cam1_empty = 1'b0;
    for (int x = 0; x < 800; x++) begin
      data_req = 1'b1; pix_x = 11'(x);
      @(negedge clk_in);
      pops0 = pops0 + int'(cam0_rd_en); pops1 = pops1 + int'(cam1_rd_en);
      n_chk++;
      if (cam0_rd_en !== (x < 400) || cam1_rd_en !== (x >= 400))
        $display("FAIL split_sel x=%0d got rd=%b%b", x, cam0_rd_en, cam1_rd_en);
      else n_pass++;
      exp_q.push_back((x < 400) ? 16'h1111 : 16'h2222);
      @(posedge clk_in); #1;
      exp_pix = exp_q.pop_front();
      n_chk++;
      if (pix_data !== exp_pix) $display("FAIL split_pix x=%0d got %h exp %h", x, pix_data, exp_pix);
      else n_pass++;
    end
    n_chk++;
    if (pops0 != 400 || pops1 != 400) $display("FAIL split_pops got %0d/%0d exp 400/400", pops0, pops1);
    else n_pass++;
    idle(5);
  endtask

  task automatic test_underflow();
    logic emp;
    cfg_mode = 2'd0;
    vsync_edge(); vsync_end(); idle(4);
    for (int x = 0; x < 20; x++) begin
      emp = (x >= 5) && (x < 10);
      data_req = 1'b1; pix_x = 11'(x); cam0_rd_data = 16'h0100 + 16'(x); cam0_empty = emp;
      @(negedge clk_in);
      n_chk++;
      if (cam0_rd_en !== ~emp || cam1_rd_en !== 1'b0)
        $display("FAIL ufl_pop x=%0d got rd=%b%b exp %b0", x, cam0_rd_en, cam1_rd_en, ~emp);
      else n_pass++;
      exp_q.push_back(emp ? 16'hF800 : (16'h0100 + 16'(x)));
      @(posedge clk_in); #1;
      exp_pix = exp_q.pop_front();
      n_chk++;
      if (pix_data !== exp_pix) $display("FAIL ufl_pix x=%0d got %h exp %h", x, pix_data, exp_pix);
      else n_pass++;
    end
    cam0_empty = 1'b0;
    idle(5);
    vsync_edge();
    n_chk++;
    if (ufl_cnt0 !== 16'd5 || ufl_cnt1 !== 16'd0)
      $display("FAIL ufl_cnt got %0d/%0d exp 5/0", ufl_cnt0, ufl_cnt1);
    else n_pass++;
    vsync_end(); idle(4);
  endtask

  task automatic test_mode_switch();
    for (int x = 0; x < 10; x++) begin
      if (x == 5) cfg_mode = 2'd1;
      data_req = 1'b1; pix_x = 11'(x); cam0_rd_data = 16'h0AAA;
      @(negedge clk_in);
      n_chk++;
      if (mode_active !== 2'd0 || cam0_rd_en !== 1'b1 || cam1_rd_en !== 1'b0)
        $display("FAIL sw_midframe x=%0d got mode=%0d rd=%b%b exp 0 10", x, mode_active, cam0_rd_en, cam1_rd_en);
      else n_pass++;
      @(posedge clk_in); #1;
    end
    idle(5);
    vsync_edge();
    n_chk++;
    if (mode_active !== 2'd1 || cam0_frame_start !== 1'b0 || cam1_frame_start !== 1'b1)
      $display("FAIL sw_edge got mode=%0d fs=%b%b exp 1 01", mode_active, cam0_frame_start, cam1_frame_start);
    else n_pass++;
    @(posedge clk_in); #1;
    n_chk++;
    if (cam0_frame_start !== 1'b0 || cam1_frame_start !== 1'b0)
      $display("FAIL sw_pulse_len got fs=%b%b exp 00", cam0_frame_start, cam1_frame_start);
    else n_pass++;
    vsync_end(); idle(4);
  endtask

  task automatic test_bars();
    cfg_mode = 2'd3;
    vsync_edge();
    n_chk++;
    if (mode_active !== 2'd3 || cam0_frame_start !== 1'b0 || cam1_frame_start !== 1'b0)
      $display("FAIL bars_edge got mode=%0d fs=%b%b exp 3 00", mode_active, cam0_frame_start, cam1_frame_start);
    else n_pass++;
    vsync_end(); idle(4);
    cam0_rd_data = 16'hABCD; cam1_rd_data = 16'hABCD;
    for (int line = 0; line < 2; line++) begin
      for (int x = 0; x < 800; x++) begin
        data_req = 1'b1; pix_x = 11'(x);
        @(negedge clk_in);
        n_chk++;
        if (cam0_rd_en !== 1'b0 || cam1_rd_en !== 1'b0)
          $display("FAIL bars_pop x=%0d got rd=%b%b exp 00", x, cam0_rd_en, cam1_rd_en);
        else n_pass++;
        exp_q.push_back(bar_tab[x / 100]);
        @(posedge clk_in); #1;
        exp_pix = exp_q.pop_front();
        n_chk++;
        if (pix_data !== exp_pix) $display("FAIL bars_pix line=%0d x=%0d got %h exp %h", line, x, pix_data, exp_pix);
        else n_pass++;
      end
      idle(6);
    end
  endtask

  task automatic test_reset_midline();
    cfg_mode = 2'd1;
    vsync_edge(); vsync_end(); idle(4);
    // Three cam1 underflows so the reported count is non-zero before reset.
    cam1_empty = 1'b1;
    for (int x = 0; x < 3; x++) begin
      data_req = 1'b1; pix_x = 11'(x);
      @(posedge clk_in); #1;
    end
    cam1_empty = 1'b0;
    idle(4);
    vsync_edge();
    n_chk++;
    if (ufl_cnt1 !== 16'd3) $display("FAIL rst_pre_ufl got %0d exp 3", ufl_cnt1);
    else n_pass++;
    vsync_end(); idle(4);
    cam1_rd_data = 16'h5A5A;
    for (int x = 0; x < 800; x++) begin
      data_req = 1'b1; pix_x = 11'(x);
      sys_rst = (x == 300);
      @(negedge clk_in);
      n_chk++;
      if (cam0_rd_en !== 1'b0 || cam1_rd_en !== (x < 300))
        $display("FAIL rst_pop x=%0d got rd=%b%b exp 0%b", x, cam0_rd_en, cam1_rd_en, (x < 300));
      else n_pass++;
      exp_q.push_back((x < 300) ? 16'h5A5A : 16'h0000);
      @(posedge clk_in); #1;
      exp_pix = exp_q.pop_front();
      n_chk++;
      if (pix_data !== exp_pix) $display("FAIL rst_pix x=%0d got %h exp %h", x, pix_data, exp_pix);
      else n_pass++;
      if (x == 300) begin
        n_chk++;
        if (mode_active !== 2'd0 || ufl_cnt1 !== 16'd0 || cam0_frame_start !== 1'b0 || cam1_frame_start !== 1'b0)
          $display("FAIL rst_outputs got mode=%0d u1=%0d fs=%b%b exp 0", mode_active, ufl_cnt1,
                   cam0_frame_start, cam1_frame_start);
        else n_pass++;
      end
    end
    sys_rst = 1'b0;
    idle(5);
    vsync_edge(); vsync_end(); idle(4);
    for (int x = 0; x < 10; x++) begin
      data_req = 1'b1; pix_x = 11'(x);
      @(negedge clk_in);
      n_chk++;
      if (cam1_rd_en !== 1'b1) $display("FAIL rst_resume x=%0d got %b exp 1", x, cam1_rd_en);
      else n_pass++;
      @(posedge clk_in); #1;
    end
    idle(3);
  endtask

  initial begin
    bar_tab[0] = 16'hFFFF; bar_tab[1] = 16'hFFE0; bar_tab[2] = 16'h07FF; bar_tab[3] = 16'h07E0;
    bar_tab[4] = 16'hF81F; bar_tab[5] = 16'hF800; bar_tab[6] = 16'h001F; bar_tab[7] = 16'h0000;
    sys_rst = 1'b1; cfg_mode = 2'd0; data_req = 1'b0; pix_x = 11'd0; vsync = 1'b0;
    cam0_rd_data = 16'h0000; cam1_rd_data = 16'h0000; cam0_empty = 1'b0; cam1_empty = 1'b0;
    #1;
    test_reset();
    test_mode0();
    test_split();
    test_underflow();
    test_mode_switch();
    test_bars();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
